// File: rtl/sisc_pkg.sv
// sisc_pkg: definitions shared across the SISC core.
//   fetch_state_t - instruction fetch FSM state encoding
//   OP_HLT        - opcode (insn[31:28]) of the HLT instruction
//   ADDR_W_DEF    - default instruction address width
//   is_hlt()      - true when an instruction word carries the HLT opcode
package sisc_pkg;

    localparam int         ADDR_W_DEF = 16;
    localparam logic [3:0] OP_HLT     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    function automatic logic is_hlt(input logic [31:0] insn);
        return insn[31:28] == OP_HLT;
    endfunction

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Holds the PC, issues one read at a time
// to instruction memory, loads the instruction register and stops on HLT.
//
// Ports
//   clk        in   clock, rising edge
//   rst_f      in   asynchronous active-low reset
//   fetch_en   in   request to fetch the next instruction
//   br_taken   in   redirect the PC to br_addr
//   br_addr    in   branch target
//   imem_req   out  memory read request, high for the whole request phase
//   imem_addr  out  memory read address (the current pc)
//   imem_ack   in   read data valid; only honoured while a request is open
//   imem_rdata in   read data
//   ir         out  instruction register
//   ir_valid   out  one-cycle pulse after ir is loaded
//   pc         out  program counter
//   halted     out  high after a HLT instruction has been loaded
//   fetch_err  out  sticky flag, set when memory fails to ack in time
module ifetch
    import sisc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err
);

    localparam int              CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              fetch_err_q, fetch_err_d;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            wait_cnt_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        wait_cnt_d  = wait_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        fetch_err_d = fetch_err_q;
        imem_req    = 1'b0;
        ir_valid    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A branch in the same cycle as fetch_en lands in pc first,
                // so the request that follows reads from the branch target.
                if (br_taken) begin
                    pc_d = br_addr;
                end
                if (fetch_en) begin
                    wait_cnt_d = '0;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d = imem_rdata;
                    // A branch arriving with the ack is the most recent one.
                    if (br_taken) begin
                        pc_d = br_addr;
                    end else if (pend_vld_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    pend_vld_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_DONE;
                end else begin
                    if (br_taken) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = br_addr;
                    end
                    // This cycle is the ACK_TIMEOUT-th one without an ack.
                    if (wait_cnt_q == CNT_LAST) begin
                        fetch_err_d = 1'b1;
                        pend_vld_d  = 1'b0;
                        wait_cnt_d  = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                ir_valid = 1'b1;
                state_d  = is_hlt(ir_q) ? ST_HALT : ST_IDLE;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic        clk;
    logic        rst_f;
    logic        fetch_en;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        halted;
    logic        fetch_err;

    ifetch #(.ADDR_W(16), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_en   (fetch_en),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] insn;
        logic [15:0] pc_after;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: remember the address of each request, and on every ir_valid
    // pop the expected transaction and compare.
    logic        req_seen = 1'b0;
    logic [15:0] req_addr = '0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (imem_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                req_addr = imem_addr;
            end else if (imem_addr !== req_addr) begin
                check("imem_addr_stable", {16'h0, imem_addr}, {16'h0, req_addr});
            end
        end
        if (ir_valid) begin
            if (prev_valid) begin
                check("ir_valid_one_cycle", 32'd1, 32'd0);
            end
            if (sb_q.size() == 0) begin
                check("unexpected_ir_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("fetch_addr", {16'h0, req_addr}, {16'h0, e.addr});
                check("ir", ir, e.insn);
                check("pc_after", {16'h0, pc}, {16'h0, e.pc_after});
            end
        end
        if (!imem_req) req_seen = 1'b0;
        prev_valid = ir_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch. lat = REQ cycle (1-based) carrying the ack;
    // mid_br drives a branch in the first REQ cycle.
    task automatic do_fetch(input logic br, input logic [15:0] ba, input int lat,
                            input logic [31:0] data, input logic mid_br,
                            input logic [15:0] mid_addr, input logic [15:0] exp_addr,
                            input logic [15:0] exp_pc);
        exp_t e;
        e.addr = exp_addr; e.insn = data; e.pc_after = exp_pc;
        sb_q.push_back(e);
        fetch_en = 1'b1; br_taken = br; br_addr = ba;
        tick();
        fetch_en = 1'b0; br_taken = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (i == 1 && mid_br) begin
                br_taken = 1'b1; br_addr = mid_addr;
            end
            if (i == lat) begin
                imem_ack = 1'b1; imem_rdata = data;
            end
            tick();
            br_taken = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fetch_en = 0; br_taken = 0; br_addr = '0; imem_ack = 0; imem_rdata = '0;
        rst_f = 1'b0;
        repeat (3) tick();
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
        rst_f = 1'b1;
        tick();

        // Basic fetch, ack in the second REQ cycle
        do_fetch(1'b0, 16'h0, 2, 32'h1234_5678, 1'b0, 16'h0, 16'h0000, 16'h0001);
        // Branch together with fetch_en
        do_fetch(1'b1, 16'h0040, 1, 32'h0000_0001, 1'b0, 16'h0, 16'h0040, 16'h0041);
        // Branch while the request is open
        do_fetch(1'b0, 16'h0, 3, 32'h0000_0002, 1'b1, 16'h0100, 16'h0041, 16'h0100);

        // Branch alone in IDLE, then wrap-around fetch
        br_taken = 1'b1; br_addr = 16'hFFFF;
        tick();
        br_taken = 1'b0;
        check("idle_branch_pc", {16'h0, pc}, 32'h0000_FFFF);
        check("idle_branch_no_req", {31'h0, imem_req}, 32'h0);
        do_fetch(1'b0, 16'h0, 1, 32'h0000_0003, 1'b0, 16'h0, 16'hFFFF, 16'h0000);

        // Ack outside REQ is ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        tick();
        check("stray_ack_ir", ir, 32'h0000_0003);
        check("stray_ack_pc", {16'h0, pc}, 32'h0);

        // Timeout, with a branch pending that must be discarded
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        br_taken = 1'b1; br_addr = 16'h0200;
        tick();
        br_taken = 1'b0;
        repeat (13) tick();
        check("timeout_req_cycle15", {31'h0, imem_req}, 32'h1);
        check("timeout_err_early", {31'h0, fetch_err}, 32'h0);
        begin
            int n = 0;
            while (!fetch_err && n < 10) begin
                tick();
                n++;
            end
            check("timeout_latency", n, 1);
        end
        check("timeout_err", {31'h0, fetch_err}, 32'h1);
        check("timeout_req_drop", {31'h0, imem_req}, 32'h0);
        check("timeout_pc", {16'h0, pc}, 32'h0);
        check("timeout_ir", ir, 32'h0000_0003);
        do_fetch(1'b0, 16'h0, 1, 32'h0000_0011, 1'b0, 16'h0, 16'h0000, 16'h0001);
        check("fetch_err_sticky", {31'h0, fetch_err}, 32'h1);

        // Reset in the middle of a request, then a late ack
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("midrst_req_open", {31'h0, imem_req}, 32'h1);
        #2 rst_f = 1'b0;
        #1;
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_pc", {16'h0, pc}, 32'h0);
        check("midrst_ir", ir, 32'h0);
        check("midrst_err", {31'h0, fetch_err}, 32'h0);
        tick();
        rst_f = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        tick();
        check("late_ack_ir", ir, 32'h0);
        check("late_ack_req", {31'h0, imem_req}, 32'h0);

        // HLT
        do_fetch(1'b0, 16'h0, 1, 32'hF000_0000, 1'b0, 16'h0, 16'h0000, 16'h0001);
        check("halted", {31'h0, halted}, 32'h1);
        fetch_en = 1'b1; br_taken = 1'b1; br_addr = 16'h0055;
        tick();
        fetch_en = 1'b0; br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("halt_no_req", {31'h0, imem_req}, 32'h0);
            tick();
        end
        check("halt_pc", {16'h0, pc}, 32'h0001);
        check("halt_still", {31'h0, halted}, 32'h1);
        rst_f = 1'b0;
        #1;
        check("halt_rst_clear", {31'h0, halted}, 32'h0);
        tick();
        rst_f = 1'b1;
        tick();

        begin
            int n = 0;
            while (sb_q.size() != 0 && n < 20) begin
                tick();
                n++;
            end
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
